fastram_responder: RTL and testbench

// - 68000-bus slave for on-board fast SRAM: the responder to the accelerator CPU's bus cycles.
// - Decodes the CPU address and drives the SRAM chip strobes.
// - Generates DTACK_FR_n, which top level ANDs into DTACK_CPU_n.
// - Asserts FR_SEL so top level suppresses AS_MB_n (a fast-RAM cycle never reaches the motherboard).
// - Runs in the C100M PLL domain; CPU strobes are asynchronous to it.

---
 rtl/fastram_responder_pkg.sv | 40 ++++
 rtl/fastram_responder_bus_sync.sv | 30 +++
 rtl/fastram_responder.sv | 160 ++++++++++++++++
 tb/tb_fastram_responder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastram_responder_pkg.sv
// ----------------------------------------------------------------------------
// fastram_responder_pkg: state encoding, region decode and address helpers.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fastram_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MISS   = 3'd1,
    ST_DECODE = 3'd2,
    ST_WDS    = 3'd3,
    ST_READ   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_ACK    = 3'd6
  } state_t;

  // Regions are 2 MB slices selected by A[23:21]; fast RAM starts at $200000.
  localparam logic [2:0]  REGION_FIRST    = 3'd1;
  localparam logic [2:0]  REGION_LAST_4MB = 3'd2;
  localparam logic [2:0]  REGION_LAST_8MB = 3'd4;
  localparam logic [2:0]  FC_CPUSPACE     = 3'b111;
  localparam logic [22:0] WORD_OFFSET     = 23'h100000;

  function automatic logic is_hit(input logic [2:0] region,
                                  input logic       jp4,
                                  input logic [2:0] fc);
    logic [2:0] last;
    last = jp4 ? REGION_LAST_8MB : REGION_LAST_4MB;
    return (fc != FC_CPUSPACE) && (region >= REGION_FIRST) && (region <= last);
  endfunction

  function automatic logic [21:0] word_addr(input logic [22:0] a);
    return 22'(a - WORD_OFFSET);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fastram_responder_bus_sync.sv
// ----------------------------------------------------------------------------
// fastram_responder_bus_sync: N-stage 1-bit synchronizer, resets to 1.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fastram_responder_bus_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

`default_nettype wire

// File: rtl/fastram_responder.sv
// ----------------------------------------------------------------------------
// fastram_responder: 68000-bus slave for on-board fast SRAM (C100M domain).
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fastram_responder
  import fastram_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_RD     = 3,
  parameter int WAIT_WR     = 3
) (
  input  logic        C100M,
  input  logic        RESET,
  input  logic        JP4,
  input  logic        AS_CPU_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic [2:0]  FC,
  input  logic [22:0] A,
  output logic [21:0] SRAM_A,
  output logic        SRAM_CE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_WE_n,
  output logic        SRAM_UB_n,
  output logic        SRAM_LB_n,
  output logic        DATA_OE,
  output logic        FR_SEL,
  output logic        DTACK_FR_n
);

  localparam logic [3:0] RD_LOAD = 4'(WAIT_RD - 1);
  localparam logic [3:0] WR_LOAD = 4'(WAIT_WR - 1);

  logic [3:0] raw_in;
  logic [3:0] sync_out;
  logic       as_s;
  logic       uds_s;
  logic       lds_s;
  logic       rw_s;

  assign raw_in = {AS_CPU_n, UDS_n, LDS_n, RW};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    fastram_responder_bus_sync #(
      .N (SYNC_STAGES)
    ) u_sync (
      .clk (C100M),
      .rst (RESET),
      .d   (raw_in[i]),
      .q   (sync_out[i])
    );
  end

  assign as_s  = sync_out[3];
  assign uds_s = sync_out[2];
  assign lds_s = sync_out[1];
  assign rw_s  = sync_out[0];

  state_t     state;
  state_t     next;
  logic [3:0] cnt;
  logic       rw_lat;
  logic       hit;
  logic       active_next;
  logic       read_drive_next;

  // A and FC are stable before AS falls, so they are decoded unsynchronized.
  assign hit = is_hit(A[22:20], JP4, FC);

  always_ff @(posedge C100M) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   if (!as_s) next = hit ? ST_DECODE : ST_MISS;
      ST_MISS:   if (as_s) next = ST_IDLE;
      ST_DECODE: begin
        if (as_s)        next = ST_IDLE;
        else if (rw_lat) next = ST_READ;
        else             next = ST_WDS;
      end
      ST_WDS: begin
        if (as_s)                 next = ST_IDLE;
        else if (!uds_s || !lds_s) next = ST_WRITE;
      end
      ST_READ, ST_WRITE: begin
        if (as_s)           next = ST_IDLE;
        else if (cnt == '0) next = ST_ACK;
      end
      ST_ACK:    if (as_s) next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state and an exit to IDLE releases everything at once.
  assign active_next     = (next == ST_WDS) || (next == ST_READ) ||
                           (next == ST_WRITE) || (next == ST_ACK);
  assign read_drive_next = (next == ST_READ) || ((next == ST_ACK) && rw_lat);

  always_ff @(posedge C100M) begin
    if (RESET) begin
      cnt        <= '0;
      rw_lat     <= 1'b1;
      SRAM_A     <= '0;
      SRAM_CE_n  <= 1'b1;
      SRAM_OE_n  <= 1'b1;
      SRAM_WE_n  <= 1'b1;
      SRAM_UB_n  <= 1'b1;
      SRAM_LB_n  <= 1'b1;
      DATA_OE    <= 1'b0;
      FR_SEL     <= 1'b0;
      DTACK_FR_n <= 1'b1;
    end else begin
      if ((state == ST_IDLE) && (next == ST_DECODE)) begin
        SRAM_A <= word_addr(A);
        rw_lat <= rw_s;
      end

      if ((state == ST_DECODE) && (next == ST_READ)) begin
        cnt <= RD_LOAD;
      end else if ((state == ST_WDS) && (next == ST_WRITE)) begin
        cnt <= WR_LOAD;
      end else if (((state == ST_READ) || (state == ST_WRITE)) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end

      FR_SEL     <= active_next;
      SRAM_CE_n  <= !active_next;
      SRAM_OE_n  <= !read_drive_next;
      DATA_OE    <= read_drive_next;
      SRAM_WE_n  <= !(next == ST_WRITE);
      DTACK_FR_n <= !(next == ST_ACK);

      // Write byte lanes are captured once, as the write strobe asserts.
      if (next == ST_READ) begin
        SRAM_UB_n <= 1'b0;
        SRAM_LB_n <= 1'b0;
      end else if ((state == ST_WDS) && (next == ST_WRITE)) begin
        SRAM_UB_n <= uds_s;
        SRAM_LB_n <= lds_s;
      end else if ((next != ST_WRITE) && (next != ST_ACK)) begin
        SRAM_UB_n <= 1'b1;
        SRAM_LB_n <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fastram_responder.sv
// ----------------------------------------------------------------------------
// tb_fastram_responder: directed self-checking bench for fastram_responder.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fastram_responder;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        JP4 = 1'b0;
  logic        AS_CPU_n = 1'b1;
  logic        UDS_n = 1'b1;
  logic        LDS_n = 1'b1;
  logic        RW = 1'b1;
  logic [2:0]  FC = 3'd5;
  logic [22:0] A = '0;
  logic [21:0] SRAM_A;
  logic        SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n;
  logic        DATA_OE, FR_SEL, DTACK_FR_n;

  int checks = 0;
  int errors = 0;

  // {FR_SEL, CE_n, OE_n, WE_n, UB_n, LB_n, DATA_OE, DTACK_n}
  localparam logic [7:0] O_IDLE  = 8'h7D;
  localparam logic [7:0] O_READ  = 8'h93;
  localparam logic [7:0] O_RACK  = 8'h92;
  localparam logic [7:0] O_WDS   = 8'hBD;
  localparam logic [7:0] O_WLB   = 8'hA9;
  localparam logic [7:0] O_WACK  = 8'hB8;

  logic [7:0] outs;
  assign outs = {FR_SEL, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n,
                 DATA_OE, DTACK_FR_n};

  fastram_responder dut (
    .C100M      (clk),
    .RESET      (RESET),
    .JP4        (JP4),
    .AS_CPU_n   (AS_CPU_n),
    .UDS_n      (UDS_n),
    .LDS_n      (LDS_n),
    .RW         (RW),
    .FC         (FC),
    .A          (A),
    .SRAM_A     (SRAM_A),
    .SRAM_CE_n  (SRAM_CE_n),
    .SRAM_OE_n  (SRAM_OE_n),
    .SRAM_WE_n  (SRAM_WE_n),
    .SRAM_UB_n  (SRAM_UB_n),
    .SRAM_LB_n  (SRAM_LB_n),
    .DATA_OE    (DATA_OE),
    .FR_SEL     (FR_SEL),
    .DTACK_FR_n (DTACK_FR_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    AS_CPU_n = 1'b1;
    UDS_n    = 1'b1;
    LDS_n    = 1'b1;
    RW       = 1'b1;
  endtask

  task automatic start(input logic [23:0] addr, input logic [2:0] fc,
                       input logic rw, input logic uds, input logic lds);
    logic [23:0] tmp;
    tmp      = addr;
    A        = tmp[23:1];
    FC       = fc;
    RW       = rw;
    UDS_n    = uds;
    LDS_n    = lds;
    AS_CPU_n = 1'b0;
  endtask

  task automatic release_and_settle(input string name);
    release_bus();
    step(); step(); step();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL %s_release: outs=%h expected %h", name, outs, O_IDLE);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    release_bus();
    step(); step(); step();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL reset_outs: outs=%h expected %h", outs, O_IDLE);
    end
    checks++;
    if (SRAM_A !== 22'h0) begin
      errors++;
      $display("FAIL reset_sram_a: got %h expected 000000", SRAM_A);
    end
    RESET = 1'b0;
    step();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL post_reset_outs: outs=%h expected %h", outs, O_IDLE);
    end
  endtask

  task automatic test_read();
    start(24'h200000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 8; e++) begin
      step();
      if (e == 2) begin
        checks++;
        if (outs !== O_IDLE) begin
          errors++;
          $display("FAIL read_e2: outs=%h expected %h", outs, O_IDLE);
        end
      end
      if (e == 3 || e == 5) begin
        checks++;
        if (outs !== O_READ) begin
          errors++;
          $display("FAIL read_e%0d: outs=%h expected %h", e, outs, O_READ);
        end
      end
      if (e == 3) begin
        checks++;
        if (SRAM_A !== 22'h000000) begin
          errors++;
          $display("FAIL read_sram_a: got %h expected 000000", SRAM_A);
        end
      end
      if (e == 6 || e == 8) begin
        checks++;
        if (outs !== O_RACK) begin
          errors++;
          $display("FAIL read_ack_e%0d: outs=%h expected %h", e, outs, O_RACK);
        end
      end
    end
    release_bus();
    for (int r = 0; r <= 2; r++) begin
      step();
      if (r == 1) begin
        checks++;
        if (outs !== O_RACK) begin
          errors++;
          $display("FAIL read_hold_r1: outs=%h expected %h", outs, O_RACK);
        end
      end
      if (r == 2) begin
        checks++;
        if (outs !== O_IDLE) begin
          errors++;
          $display("FAIL read_release_r2: outs=%h expected %h", outs, O_IDLE);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    int we_cycles;
    we_cycles = 0;
    start(24'h3FFFFF, 3'd5, 1'b0, 1'b1, 1'b1);
    for (int e = 0; e <= 11; e++) begin
      step();
      if (SRAM_WE_n === 1'b0) we_cycles++;
      if (e == 3 || e == 6) begin
        checks++;
        if (outs !== O_WDS) begin
          errors++;
          $display("FAIL write_wds_e%0d: outs=%h expected %h", e, outs, O_WDS);
        end
      end
      if (e == 3) begin
        checks++;
        if (SRAM_A !== 22'h0FFFFF) begin
          errors++;
          $display("FAIL write_sram_a: got %h expected 0fffff", SRAM_A);
        end
      end
      if (e == 7 || e == 9) begin
        checks++;
        if (outs !== O_WLB) begin
          errors++;
          $display("FAIL write_we_e%0d: outs=%h expected %h", e, outs, O_WLB);
        end
      end
      if (e == 10) begin
        checks++;
        if (outs !== O_WACK) begin
          errors++;
          $display("FAIL write_ack: outs=%h expected %h", outs, O_WACK);
        end
      end
      if (e == 4) LDS_n = 1'b0;
    end
    checks++;
    if (we_cycles != 3) begin
      errors++;
      $display("FAIL write_we_width: got %0d cycles expected 3", we_cycles);
    end
    release_and_settle("write");
  endtask

  task automatic test_region_jp4();
    JP4 = 1'b0;
    start(24'h700000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 3 || e == 7) begin
        checks++;
        if (outs !== O_IDLE) begin
          errors++;
          $display("FAIL miss_jp4_0_e%0d: outs=%h expected %h", e, outs, O_IDLE);
        end
      end
    end
    release_and_settle("miss");
    JP4 = 1'b1;
    start(24'h700000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 3) begin
        checks++;
        if (SRAM_A !== 22'h280000) begin
          errors++;
          $display("FAIL hit_jp4_1_sram_a: got %h expected 280000", SRAM_A);
        end
      end
      if (e == 6) begin
        checks++;
        if (outs !== O_RACK) begin
          errors++;
          $display("FAIL hit_jp4_1_ack: outs=%h expected %h", outs, O_RACK);
        end
      end
    end
    release_and_settle("hit_jp4");
    JP4 = 1'b0;
  endtask

  task automatic test_cpu_space();
    start(24'h200000, 3'b111, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 3 || e == 7) begin
        checks++;
        if (outs !== O_IDLE) begin
          errors++;
          $display("FAIL cpu_space_e%0d: outs=%h expected %h", e, outs, O_IDLE);
        end
      end
    end
    release_and_settle("cpu_space");
    FC = 3'd5;
  endtask

  task automatic test_reset_mid_read();
    logic dtack_seen;
    dtack_seen = 1'b0;
    start(24'h400000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 4; e++) begin
      step();
      if (e == 3) begin
        checks++;
        if (SRAM_A !== 22'h100000) begin
          errors++;
          $display("FAIL rst_mid_sram_a: got %h expected 100000", SRAM_A);
        end
      end
      if (e == 4) begin
        checks++;
        if (outs !== O_READ) begin
          errors++;
          $display("FAIL rst_mid_pre: outs=%h expected %h", outs, O_READ);
        end
      end
    end
    RESET = 1'b1;
    release_bus();
    step();
    checks++;
    if (outs !== O_IDLE || SRAM_A !== 22'h0) begin
      errors++;
      $display("FAIL rst_mid_next_edge: outs=%h sram_a=%h expected %h/000000",
               outs, SRAM_A, O_IDLE);
    end
    RESET = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (DTACK_FR_n !== 1'b1) dtack_seen = 1'b1;
    end
    checks++;
    if (dtack_seen) begin
      errors++;
      $display("FAIL rst_mid_no_dtack: dtack asserted expected none");
    end
  endtask

  task automatic test_aborted_write();
    logic we_seen;
    we_seen = 1'b0;
    start(24'h300000, 3'd5, 1'b0, 1'b1, 1'b1);
    for (int e = 0; e <= 10; e++) begin
      step();
      if (SRAM_WE_n !== 1'b1) we_seen = 1'b1;
      if (e == 3 || e == 6) begin
        checks++;
        if (outs !== O_WDS) begin
          errors++;
          $display("FAIL abort_wds_e%0d: outs=%h expected %h", e, outs, O_WDS);
        end
      end
      if (e == 7) begin
        checks++;
        if (outs !== O_IDLE) begin
          errors++;
          $display("FAIL abort_idle: outs=%h expected %h", outs, O_IDLE);
        end
      end
      if (e == 4) release_bus();
    end
    checks++;
    if (we_seen) begin
      errors++;
      $display("FAIL abort_we: we asserted expected never");
    end
    start(24'h500000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 3) begin
        checks++;
        if (SRAM_A !== 22'h180000) begin
          errors++;
          $display("FAIL abort_next_sram_a: got %h expected 180000", SRAM_A);
        end
      end
      if (e == 6) begin
        checks++;
        if (outs !== O_RACK) begin
          errors++;
          $display("FAIL abort_next_ack: outs=%h expected %h", outs, O_RACK);
        end
      end
    end
    release_and_settle("abort_next");
  endtask

  task automatic test_back_to_back();
    start(24'h200000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 6) begin
        checks++;
        if (outs !== O_RACK) begin
          errors++;
          $display("FAIL b2b_first_ack: outs=%h expected %h", outs, O_RACK);
        end
      end
    end
    release_bus();
    step();
    start(24'h420000, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int g = 1; g <= 7; g++) begin
      step();
      if (g == 2) begin
        checks++;
        if (outs !== O_IDLE) begin
          errors++;
          $display("FAIL b2b_gap_idle: outs=%h expected %h", outs, O_IDLE);
        end
      end
      if (g == 4) begin
        checks++;
        if (outs !== O_READ || SRAM_A !== 22'h110000) begin
          errors++;
          $display("FAIL b2b_second_read: outs=%h sram_a=%h expected %h/110000",
                   outs, SRAM_A, O_READ);
        end
      end
      if (g == 7) begin
        checks++;
        if (outs !== O_RACK) begin
          errors++;
          $display("FAIL b2b_second_ack: outs=%h expected %h", outs, O_RACK);
        end
      end
    end
    release_and_settle("b2b");
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_region_jp4();
    test_cpu_space();
    test_reset_mid_read();
    test_aborted_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
